// File: rtl/commit_ctrl_if.sv
// commit_ctrl_if: ROB head, retirement RAT, free list and recovery signals of the commit stage
//   master: commit_ctrl side (drives dequeue, RRAT write, free-list push, flush and restore)
//   slave : pipeline side (drives ROB head, RRAT kick/map and free-list status)
interface commit_ctrl_if #(parameter int PW = 6);
    logic                 rob_head_valid;
    logic                 rob_head_done;
    logic [4:0]           rob_head_rd_s;
    logic [PW-1:0]        rob_head_pd;
    logic                 rob_head_mispredict;
    logic                 rob_dequeue;
    logic                 rrat_wen;
    logic [4:0]           rrat_rd_s;
    logic [PW-1:0]        rrat_p_addr;
    logic                 rrat_kick;
    logic [PW-1:0]        rrat_kick_p_addr;
    logic [31:0][PW-1:0]  rrat_map;
    logic                 freelist_full;
    logic                 freelist_push;
    logic [PW-1:0]        freelist_push_addr;
    logic                 freelist_restore;
    logic                 flush;
    logic                 rat_restore_wen;
    logic [4:0]           rat_restore_idx;
    logic [PW-1:0]        rat_restore_p_addr;
    logic                 busy;
    logic [31:0]          commit_count;
    modport master (
        input  rob_head_valid, rob_head_done, rob_head_rd_s, rob_head_pd, rob_head_mispredict,
               rrat_kick, rrat_kick_p_addr, rrat_map, freelist_full,
        output rob_dequeue, rrat_wen, rrat_rd_s, rrat_p_addr, freelist_push, freelist_push_addr,
               freelist_restore, flush, rat_restore_wen, rat_restore_idx, rat_restore_p_addr,
               busy, commit_count
    );
    modport slave (
        output rob_head_valid, rob_head_done, rob_head_rd_s, rob_head_pd, rob_head_mispredict,
               rrat_kick, rrat_kick_p_addr, rrat_map, freelist_full,
        input  rob_dequeue, rrat_wen, rrat_rd_s, rrat_p_addr, freelist_push, freelist_push_addr,
               freelist_restore, flush, rat_restore_wen, rat_restore_idx, rat_restore_p_addr,
               busy, commit_count
    );
endinterface

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order single-commit retirement with mispredict flush and speculative RAT rebuild
//   clk, rst : clock and synchronous active-high reset
//   bus      : commit_ctrl_if.master (ROB head in, RRAT/free-list/recovery controls out)
module commit_ctrl #(
    parameter int ROB_DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    commit_ctrl_if.master bus
);
    localparam int PW = $clog2(ROB_DEPTH + 32);
    typedef enum logic [1:0] {RUN, FLUSH, RESTORE} state_t;
    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          commit, wr, rest;
    logic [PW-1:0] map_sel;
    always_comb begin
        commit  = ~rst & (state_q == RUN) & bus.rob_head_valid & bus.rob_head_done
                  & ~(bus.freelist_full & (bus.rob_head_rd_s != 5'd0));
        wr      = commit & (bus.rob_head_rd_s != 5'd0);
        rest    = ~rst & (state_q == RESTORE);
        map_sel = bus.rrat_map[idx_q];
        bus.rob_dequeue        = commit;
        bus.rrat_wen           = wr;
        bus.rrat_rd_s          = rst ? '0 : bus.rob_head_rd_s;
        bus.rrat_p_addr        = rst ? '0 : bus.rob_head_pd;
        bus.freelist_push      = wr & bus.rrat_kick;
        bus.freelist_push_addr = rst ? '0 : bus.rrat_kick_p_addr;
        bus.flush              = ~rst & (state_q == FLUSH);
        bus.freelist_restore   = ~rst & (state_q == FLUSH);
        bus.rat_restore_wen    = rest;
        bus.rat_restore_idx    = rest ? idx_q : '0;
        bus.rat_restore_p_addr = rest ? map_sel : '0;
        bus.busy               = ~rst & (state_q != RUN);
        bus.commit_count       = rst ? '0 : cnt_q;
        state_d = state_q == RUN   ? ((commit & bus.rob_head_mispredict) ? FLUSH : RUN) :
                  state_q == FLUSH ? RESTORE :
                  (idx_q == 5'd31) ? RUN : RESTORE;
        // the walk counter wraps 31->0, so it is already clear for the next recovery
        idx_d   = state_q == RESTORE ? idx_q + 5'd1 : '0;
        cnt_d   = cnt_q + 32'(commit);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: scoreboard bench for commit_ctrl
module tb_commit_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    commit_ctrl_if #(.PW(6)) bus();
    commit_ctrl #(.ROB_DEPTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic        deq;
        logic [11:0] rrat;
        logic [6:0]  fl;
        logic [14:0] rec;
        logic [31:0] cnt;
    } exp_t;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          m_rec = 0;
    logic [31:0] m_cnt = '0;
    logic [5:0]  map[32];
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input logic r, input logic v, input logic dn, input logic [4:0] rd,
                       input logic [5:0] pd, input logic mis, input logic full,
                       input logic kick, input logic [5:0] ka);
        exp_t e;
        logic c;
        @(posedge clk);
        #1;
        rst = r;
        bus.rob_head_valid = v;
        bus.rob_head_done = dn;
        bus.rob_head_rd_s = rd;
        bus.rob_head_pd = pd;
        bus.rob_head_mispredict = mis;
        bus.freelist_full = full;
        bus.rrat_kick = kick;
        bus.rrat_kick_p_addr = ka;
        e = '0;
        if (r) begin
            m_rec = 0;
            m_cnt = '0;
        end else if (m_rec == 0) begin
            c = v & dn & ~(full & (rd != 5'd0));
            e.deq = c;
            e.rrat = {c & (rd != 5'd0), rd, pd};
            e.fl = {c & (rd != 5'd0) & kick, ka};
            e.cnt = m_cnt;
            m_cnt = m_cnt + 32'(c);
            if (c & mis) m_rec = 1;
        end else if (m_rec == 1) begin
            e.rrat = {1'b0, rd, pd};
            e.fl = {1'b0, ka};
            e.rec = {1'b1, 1'b1, 1'b0, 5'd0, 6'd0, 1'b1};
            e.cnt = m_cnt;
            m_rec = 2;
        end else begin
            e.rrat = {1'b0, rd, pd};
            e.fl = {1'b0, ka};
            e.rec = {1'b0, 1'b0, 1'b1, 5'(m_rec - 2), map[m_rec - 2], 1'b1};
            e.cnt = m_cnt;
            m_rec = (m_rec == 33) ? 0 : m_rec + 1;
        end
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check("dequeue", 64'(bus.rob_dequeue), 64'(e.deq));
        check("rrat", 64'({bus.rrat_wen, bus.rrat_rd_s, bus.rrat_p_addr}), 64'(e.rrat));
        check("freelist", 64'({bus.freelist_push, bus.freelist_push_addr}), 64'(e.fl));
        check("recovery", 64'({bus.flush, bus.freelist_restore, bus.rat_restore_wen,
                               bus.rat_restore_idx, bus.rat_restore_p_addr, bus.busy}), 64'(e.rec));
        check("commit_count", 64'(bus.commit_count), 64'(e.cnt));
    endtask
    initial begin
        for (int i = 0; i < 32; i++) begin
            map[i] = 6'($urandom);
            bus.rrat_map[i] = map[i];
        end
        repeat (2) cyc(1, 1, 1, 5, 40, 1, 0, 1, 5);
        cyc(0, 1, 1, 5, 40, 0, 0, 1, 5);
        cyc(0, 1, 1, 0, 7, 0, 0, 1, 9);
        repeat (4) cyc(0, 1, 1, 3, 20, 0, 1, 1, 2);
        cyc(0, 1, 1, 3, 20, 0, 0, 1, 2);
        repeat (3) cyc(0, 1, 0, 8, 12, 0, 0, 1, 4);
        cyc(0, 1, 1, 8, 12, 0, 0, 1, 4);
        repeat (2) cyc(0, 1, 1, 4, 30, 1, 1, 0, 0);
        cyc(0, 1, 1, 4, 30, 1, 0, 1, 7);
        repeat (34) cyc(0, 1, 1, 6, 33, 0, 0, 1, 3);
        cyc(0, 1, 1, 0, 0, 1, 0, 0, 0);
        repeat (11) cyc(0, 1, 1, 2, 17, 0, 0, 1, 1);
        cyc(1, 1, 1, 2, 17, 0, 0, 1, 1);
        cyc(0, 1, 1, 9, 11, 1, 0, 0, 0);
        repeat (36) cyc(0, 1, 1, 2, 17, 0, 0, 1, 1);
        repeat (400) cyc($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
                         5'($urandom), 6'($urandom), $urandom_range(0, 7) == 0,
                         $urandom_range(0, 3) == 0, 1'($urandom), 6'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
